// File: rtl/timer_ctrl.sv
// timer_ctrl: debounced start/clear buttons driving an IDLE/RUN/PAUSE/DONE sequencer with a tick divider; all outputs registered.
// Build option TIMER_CTRL_AUTORELOAD_EN: DONE expiry reloads and re-enters RUN instead of returning to IDLE.
module timer_ctrl #(
  parameter int TICK_DIV   = 12000000,
  parameter int FAST_DIV   = 6000000,
  parameter int DEB_CYCLES = 240000,
  parameter int DONE_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       set_fast,
  input  logic       cnt_zero,
  output logic       tick_en,
  output logic       load,
  output logic       run,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int DIVW = $clog2(TICK_DIV);
  localparam int DNW  = $clog2(DONE_TICKS + 1);

  // Index 0 is the start button, index 1 the clear button.
  logic [1:0]    sync1_q, sync2_q, stable_q, evt_q;
  logic [DW-1:0] deb_cnt_q [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      evt_q    <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= {btn_clear, btn_start};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        evt_q[i] <= 1'b0;
        if (sync2_q[i] == stable_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          stable_q[i]  <= sync2_q[i];
          deb_cnt_q[i] <= '0;
          evt_q[i]     <= sync2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic            start_evt, clear_evt;
  logic [DIVW-1:0] div_q, div_d, lim_m1;
  logic [DNW-1:0]  done_q, done_d;
  logic [1:0]      state_d;
  logic            tick_d, load_d;

  assign start_evt = evt_q[0];
  assign clear_evt = evt_q[1];
  assign lim_m1    = set_fast ? DIVW'(FAST_DIV - 1) : DIVW'(TICK_DIV - 1);

  always_comb begin
    state_d = state;
    div_d   = div_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    load_d  = 1'b0;
    // ">=" also catches a switch to the fast rate while div is already past the new limit.
    if (state == S_RUN || state == S_DONE) begin
      if (div_q >= lim_m1) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    if (clear_evt) begin
      state_d = S_IDLE;
      tick_d  = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_evt) begin
          state_d = S_RUN;
          load_d  = 1'b1;
          div_d   = '0;
        end
        S_RUN: begin
          if (cnt_zero) begin
            state_d = S_DONE;
            done_d  = '0;
          end else if (start_evt) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: if (start_evt) state_d = S_RUN;
        S_DONE: begin
          if (start_evt) begin
            state_d = S_RUN;
            load_d  = 1'b1;
            div_d   = '0;
            tick_d  = 1'b0;
          end else if (tick_en) begin
            if (done_q == DNW'(DONE_TICKS - 1)) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
              state_d = S_RUN;
              load_d  = 1'b1;
              div_d   = '0;
              tick_d  = 1'b0;
`else
              state_d = S_IDLE;
`endif
            end else begin
              done_d = done_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      div_q   <= '0;
      done_q  <= '0;
      tick_en <= 1'b0;
      load    <= 1'b0;
      run     <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state   <= state_d;
      div_q   <= div_d;
      done_q  <= done_d;
      tick_en <= tick_d;
      load    <= load_d;
      run     <= (state_d == S_RUN);
      alarm   <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random button/cnt_zero/set_fast traffic, checked every cycle against a reference model.
module tb_timer_ctrl;
  localparam int TD = 10;
  localparam int FD = 4;
  localparam int DB = 3;
  localparam int DT = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic btn_start = 1'b0, btn_clear = 1'b0, set_fast = 1'b0, cnt_zero = 1'b0;
  logic tick_en, load, run, alarm;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;

  timer_ctrl #(.TICK_DIV(TD), .FAST_DIV(FD), .DEB_CYCLES(DB), .DONE_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
    .set_fast(set_fast), .cnt_zero(cnt_zero), .tick_en(tick_en), .load(load),
    .run(run), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state as a number, divider as cycles since last tick,
  // a button level is accepted once the last DB synchronized samples all disagree with it.
  int m_st, m_div, m_done;
  bit m_tick, m_load;
  bit m_evt  [2];
  bit m_stab [2];
  bit hs     [2][8];

  task automatic model_reset();
    m_st = 0; m_div = 0; m_done = 0; m_tick = 0; m_load = 0;
    for (int b = 0; b < 2; b++) begin
      m_evt[b] = 0; m_stab[b] = 0;
      for (int k = 0; k < 8; k++) hs[b][k] = 0;
    end
  endtask

  task automatic model_edge();
    bit btn [2];
    bit nevt [2];
    bit acc, ntick, nload;
    int nst, ndiv, ndone, lim;
    btn[0] = btn_start; btn[1] = btn_clear;
    nst = m_st; ndiv = m_div; ndone = m_done; ntick = 0; nload = 0;
    if (m_st == 1 || m_st == 3) begin
      lim = set_fast ? FD : TD;
      if (m_div >= lim - 1) begin ndiv = 0; ntick = 1; end
      else ndiv = m_div + 1;
    end
    if (m_evt[1]) begin
      nst = 0; ntick = 0;
    end else begin
      case (m_st)
        0: if (m_evt[0]) begin nst = 1; nload = 1; ndiv = 0; end
        1: if (cnt_zero) begin nst = 3; ndone = 0; end
           else if (m_evt[0]) nst = 2;
        2: if (m_evt[0]) nst = 1;
        default: begin
          if (m_evt[0]) begin
            nst = 1; nload = 1; ndiv = 0; ntick = 0;
          end else if (m_tick) begin
            if (m_done + 1 >= DT) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
              nst = 1; nload = 1; ndiv = 0; ntick = 0;
`else
              nst = 0;
`endif
            end else ndone = m_done + 1;
          end
        end
      endcase
    end
    for (int b = 0; b < 2; b++) begin
      for (int k = 7; k > 0; k--) hs[b][k] = hs[b][k-1];
      hs[b][0] = btn[b];
      acc = 1;
      for (int k = 2; k < 2 + DB; k++) if (hs[b][k] == m_stab[b]) acc = 0;
      nevt[b] = acc && !m_stab[b];
      if (acc) m_stab[b] = !m_stab[b];
    end
    m_st = nst; m_div = ndiv; m_done = ndone; m_tick = ntick; m_load = nload;
    m_evt[0] = nevt[0]; m_evt[1] = nevt[1];
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_edge();
  end

  task automatic step();
    @(negedge clk);
    chk("state", 32'(state), 32'(m_st));
    chk("tick_en", 32'(tick_en), 32'(m_tick));
    chk("load", 32'(load), 32'(m_load));
    chk("run", 32'(run), 32'(m_st == 1));
    chk("alarm", 32'(alarm), 32'(m_st == 3));
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) btn_start = 1'b1;
    else btn_clear = 1'b1;
    repeat (hold) step();
    btn_start = 1'b0;
    btn_clear = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    int h, k;
    bit found;
    int nticks;

    repeat (3) step();
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", 32'({tick_en, load, run, alarm}), 0);
    rst = 1'b1;
    repeat (3) step();

    // Glitchy press never holds DB consecutive samples.
    for (int i = 0; i < 5; i++) begin
      btn_start = (i != 2);
      step();
    end
    btn_start = 1'b0;
    repeat (10) step();
    chk("glitch_idle", 32'(state), 0);

    // Clean press: state/load on the 6th observed cycle, ticks 10 and 20 cycles after load.
    btn_start = 1'b1;
    for (int s = 1; s <= 26; s++) begin
      step();
      if (s == 5)  chk("start_lat_before", 32'(state), 0);
      if (s == 6)  begin chk("start_lat_state", 32'(state), 1); chk("start_load", 32'(load), 1); end
      if (s == 7)  chk("load_one_cycle", 32'(load), 0);
      if (s == 15) chk("tick_not_early", 32'(tick_en), 0);
      if (s == 16) chk("first_tick", 32'(tick_en), 1);
      if (s == 20) btn_start = 1'b0;
      if (s == 26) chk("second_tick", 32'(tick_en), 1);
    end
    repeat (8) step();

    // Pause, hold 50 cycles with no ticks, resume from held divider.
    press(0, 8);
    chk("paused", 32'(state), 2);
    nticks = 0;
    repeat (50) begin step(); if (tick_en) nticks++; end
    chk("pause_no_tick", 32'(nticks), 0);
    h = m_div;
    btn_start = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin step(); if (state == 2'd1) found = 1; end
    chk("resume_seen", 32'(found), 1);
    btn_start = 1'b0;
    found = 0; k = 0;
    for (int i = 0; i < 20 && !found; i++) begin step(); k++; if (tick_en) found = 1; end
    chk("resume_tick_gap", 32'(k), 32'(TD - h));
    repeat (8) step();

    // Switch to fast rate with div at 7: immediate tick then period FD.
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin step(); if (m_div == 7) found = 1; end
    chk("div7_reached", 32'(found), 1);
    set_fast = 1'b1;
    step();
    chk("fast_immediate", 32'(tick_en), 1);
    repeat (FD - 1) step();
    chk("fast_gap", 32'(tick_en), 0);
    step();
    chk("fast_period", 32'(tick_en), 1);
    set_fast = 1'b0;

    // Terminal count in RUN.
    cnt_zero = 1'b1;
    step();
    cnt_zero = 1'b0;
    chk("done_state", 32'(state), 3);
    chk("done_alarm", 32'(alarm), 1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin step(); if (state != 2'd3) found = 1; end
    chk("done_exit", 32'(found), 1);
`ifdef TIMER_CTRL_AUTORELOAD_EN
    chk("reload_state", 32'(state), 1);
    chk("reload_load", 32'(load), 1);
`else
    chk("expire_state", 32'(state), 0);
    chk("expire_alarm", 32'(alarm), 0);
`endif
    repeat (3) step();

    // Clear and start land in the same cycle while paused.
    if (state == 2'd0) press(0, 8);
    press(0, 8);
    chk("pause_again", 32'(state), 2);
    btn_start = 1'b1;
    btn_clear = 1'b1;
    found = 0;
    for (int i = 0; i < 15 && !found; i++) begin step(); if (state != 2'd2) found = 1; end
    chk("clr_beats_start", 32'(state), 0);
    chk("clr_no_load", 32'(load), 0);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    repeat (8) step();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 59) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 79) == 0) set_fast = ~set_fast;
      cnt_zero = ($urandom_range(0, 29) == 0);
      step();
    end
    btn_start = 1'b0; btn_clear = 1'b0; set_fast = 1'b0; cnt_zero = 1'b0;
    repeat (8) step();

    // Asynchronous reset while in DONE.
    press(1, 8);
    press(0, 8);
    cnt_zero = 1'b1;
    step();
    cnt_zero = 1'b0;
    chk("pre_reset_done", 32'(state), 3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_outs", 32'({tick_en, load, run, alarm}), 0);
    repeat (3) step();
    rst = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Run/pause/done sequencer for the seconds counter and seven-segment datapath. Debounces the start and clear buttons, generates the single-cycle count-enable tick at normal or fast rate, issues the preset-load strobe, and drives the alarm indication when the count reaches its terminal value. It sits between the board push-buttons and the counter, replacing free-running divided clocks and toggle flops with one clock domain and explicit strobes.

## Interface
Parameters:
- TICK_DIV, 12000000: clk cycles per tick at normal rate (1 s at 12 MHz).
- FAST_DIV, 6000000: clk cycles per tick when set_fast=1. Must satisfy 2 ≤ FAST_DIV ≤ TICK_DIV.
- DEB_CYCLES, 240000: consecutive identical synchronized samples required to accept a button level (20 ms).
- DONE_TICKS, 5: ticks spent in DONE before leaving it automatically. Must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw start/pause button, active high, asynchronous to clk.
- btn_clear  in  1  raw clear button, active high, asynchronous to clk.
- set_fast  in  1  level; selects FAST_DIV.
- cnt_zero  in  1  from the datapath; high while the count is at its terminal value.
- tick_en  out  1  one-cycle count enable to the datapath.
- load  out  1  one-cycle preset-load strobe to the datapath.
- run  out  1  high in RUN.
- alarm  out  1  high in DONE.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Buttons: 2-FF synchronizer, then a debounce counter of width $clog2(DEB_CYCLES+1). A stable level changes only after DEB_CYCLES consecutive samples differ from it. Any matching sample clears the counter. start_evt and clear_evt are one-cycle pulses on a rising edge of the stable level. A falling edge produces no event.
- Divider: width $clog2(TICK_DIV). Counts only in RUN and DONE. limit = set_fast ? FAST_DIV : TICK_DIV. When div ≥ limit-1: div←0 and tick_en=1 next cycle. This also covers set_fast asserting while div already exceeds the new limit: one immediate tick, then wrap. In PAUSE the divider holds. Entering RUN from IDLE or DONE clears it; entering RUN from PAUSE resumes from the held value.
- FSM, evaluated in priority order:
  - clear_evt in any state → IDLE, with no load strobe.
  - IDLE: start_evt → RUN, load=1.
  - RUN: cnt_zero=1 → DONE. Otherwise start_evt → PAUSE.
  - PAUSE: start_evt → RUN.
  - DONE: start_evt → RUN, load=1. Otherwise, after DONE_TICKS ticks (done counter cleared on entry) → IDLE.
- tick_en is suppressed in PAUSE and IDLE. tick_en pulses in DONE advance only the done counter; the datapath ignores them because run=0.

## Timing
- Reset: state=IDLE, tick_en=0, load=0, run=0, alarm=0, div=0, done counter=0, stable levels=0, synchronizers=0. Reset mid-operation aborts immediately and asynchronously.
- All outputs are registered.
- Button-to-event latency: a clean press yields start_evt exactly 2+DEB_CYCLES cycles after the first high sample.
- Event to state/load: 1 cycle. load and the new state value appear in the same cycle.
- First tick after load: TICK_DIV cycles after load (FAST_DIV if set_fast=1).
- cnt_zero → alarm: 1 cycle. cnt_zero is ignored outside RUN.
- Simultaneous events: clear beats start. cnt_zero beats start in RUN. A tick and start_evt in the same RUN cycle: the tick is still issued and the state goes to PAUSE.

## Configuration
- TIMER_CTRL_AUTORELOAD_EN defined: when the DONE_TICKS count expires in DONE, the FSM goes to RUN with load=1 and the divider cleared (repeating timer).
- Undefined: DONE expiry goes to IDLE as specified above.
- All other behaviour is identical in both builds.

## Test plan
Parameters for all scenarios: TICK_DIV=10, FAST_DIV=4, DEB_CYCLES=3, DONE_TICKS=2.
- Reset, then press btn_start clean for 20 cycles:
  - start_evt 5 cycles after the first high sample.
  - Next cycle: state=1, load=1 for one cycle.
  - tick_en every 10 cycles.
- Glitchy start (high 2 cycles, low 1, high 2) → no event, state stays 0.
- In RUN, second press → state=2, no tick_en for 50 cycles. Third press → state=1 and the next tick arrives at the remaining divider count, not a full 10.
- Toggle set_fast=1 mid-RUN at div=7 → tick on the next cycle, then every 4 cycles.
- Raise cnt_zero in RUN:
  - Default build: alarm=1 next cycle; state=3 for 2 ticks, then state=0 with alarm=0.
  - With TIMER_CTRL_AUTORELOAD_EN: state=1 with load=1 instead.
- Assert clear_evt and start_evt in the same cycle while in PAUSE → state=0, load=0. Drop rst mid-DONE → all outputs 0 immediately.
